// File: rtl/phase_pair_if.sv
// Handshake/config/output bundle for the dual-channel square-wave generator.
// Ports: enable, cfg_load strobe with cfg_period/cfg_high/cfg_delay in; cfg_ok/cfg_err pulses,
//        sig_a/sig_b waves, period_tick and running out. master = stimulus side, slave = generator.
interface phase_pair_if #(
    parameter int CNT_W = 32
);
    logic             enable;
    logic             cfg_load;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_high;
    logic [CNT_W-1:0] cfg_delay;
    logic             cfg_ok;
    logic             cfg_err;
    logic             sig_a;
    logic             sig_b;
    logic             period_tick;
    logic             running;

    modport master (
        output enable, cfg_load, cfg_period, cfg_high, cfg_delay,
        input  cfg_ok, cfg_err, sig_a, sig_b, period_tick, running
    );

    modport slave (
        input  enable, cfg_load, cfg_period, cfg_high, cfg_delay,
        output cfg_ok, cfg_err, sig_a, sig_b, period_tick, running
    );
endinterface

// File: rtl/phase_pair_gen.sv
// Dual square-wave generator: sig_a reference, sig_b lagging it by cfg_delay cycles.
// Latency: outputs registered, one cycle behind counter state; cfg_ok/cfg_err one cycle after cfg_load.
// Backpressure: none; a valid load is staged in pending regs and applied in IDLE or at a period wrap.
// Ports: clk, rst (sync, active-high), bus (phase_pair_if.slave) carrying enable/cfg in and waves out.
module phase_pair_gen #(
    parameter int CNT_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    phase_pair_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
    logic [CNT_W-1:0] act_period_q, act_period_d;
    logic [CNT_W-1:0] act_high_q, act_high_d;
    logic [CNT_W-1:0] act_delay_q, act_delay_d;
    logic             act_valid_q, act_valid_d;
    logic [CNT_W-1:0] pend_period_q, pend_period_d;
    logic [CNT_W-1:0] pend_high_q, pend_high_d;
    logic [CNT_W-1:0] pend_delay_q, pend_delay_d;
    logic             pend_q, pend_d;
    logic             cfg_ok_q, cfg_ok_d;
    logic             cfg_err_q, cfg_err_d;
    logic             sig_a_q, sig_a_d;
    logic             sig_b_q, sig_b_d;
    logic             tick_q, tick_d;

    logic             cfg_good;
    logic [CNT_W-1:0] per_last;
    logic             wrap;
    logic             release_b;
    logic             running;
    logic             apply;

    always_comb begin
        cfg_good  = (bus.cfg_period >= CNT_W'(2)) &&
                    (bus.cfg_high != '0) &&
                    (bus.cfg_high < bus.cfg_period) &&
                    (bus.cfg_delay < bus.cfg_period);
        per_last  = act_period_q - CNT_W'(1);
        running   = (state_q != S_IDLE);
        wrap      = running && (cnt_a_q == per_last);
        // The cycle where cnt_a reaches the delay is the first cycle of cnt_b;
        // it already counts as "running" for sig_b so the lag is exactly act_delay.
        release_b = (state_q == S_ALIGN) && (cnt_a_q == act_delay_q);
    end

    always_comb begin
        state_d       = state_q;
        cnt_a_d       = cnt_a_q;
        cnt_b_d       = cnt_b_q;
        act_period_d  = act_period_q;
        act_high_d    = act_high_q;
        act_delay_d   = act_delay_q;
        act_valid_d   = act_valid_q;
        pend_period_d = pend_period_q;
        pend_high_d   = pend_high_q;
        pend_delay_d  = pend_delay_q;
        pend_d        = pend_q;
        cfg_ok_d      = 1'b0;
        cfg_err_d     = 1'b0;
        apply         = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_a_d = '0;
                cnt_b_d = '0;
                if (pend_q) apply = 1'b1;
                if (bus.enable && act_valid_q) state_d = S_ALIGN;
            end
            S_ALIGN: begin
                cnt_a_d = wrap ? '0 : cnt_a_q + CNT_W'(1);
                cnt_b_d = release_b ? CNT_W'(1) : '0;
                if (!bus.enable && cnt_a_q == '0) begin
                    // Dropped before the alignment period really started: leave at once.
                    state_d = S_IDLE;
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                end else if (wrap && !bus.enable) begin
                    state_d = S_IDLE;
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                end else if (wrap && pend_q) begin
                    apply   = 1'b1;
                    state_d = S_ALIGN;
                    cnt_b_d = '0;
                end else if (release_b) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cnt_a_d = wrap ? '0 : cnt_a_q + CNT_W'(1);
                cnt_b_d = (cnt_b_q == per_last) ? '0 : cnt_b_q + CNT_W'(1);
                if (wrap && !bus.enable) begin
                    state_d = S_IDLE;
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                end else if (wrap && pend_q) begin
                    apply   = 1'b1;
                    state_d = S_ALIGN;
                    cnt_b_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_a_d = '0;
                cnt_b_d = '0;
            end
        endcase

        if (apply) begin
            act_period_d = pend_period_q;
            act_high_d   = pend_high_q;
            act_delay_d  = pend_delay_q;
            act_valid_d  = 1'b1;
            pend_d       = 1'b0;
        end

        // A load on the apply cycle lands in pending after the old pending was consumed.
        if (bus.cfg_load) begin
            if (cfg_good) begin
                pend_period_d = bus.cfg_period;
                pend_high_d   = bus.cfg_high;
                pend_delay_d  = bus.cfg_delay;
                pend_d        = 1'b1;
                cfg_ok_d      = 1'b1;
            end else begin
                cfg_err_d     = 1'b1;
            end
        end

        sig_a_d = running && (cnt_a_q < act_high_q);
        sig_b_d = ((state_q == S_RUN) || release_b) && (cnt_b_q < act_high_q);
        tick_d  = wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_a_q       <= '0;
            cnt_b_q       <= '0;
            act_period_q  <= '0;
            act_high_q    <= '0;
            act_delay_q   <= '0;
            act_valid_q   <= 1'b0;
            pend_period_q <= '0;
            pend_high_q   <= '0;
            pend_delay_q  <= '0;
            pend_q        <= 1'b0;
            cfg_ok_q      <= 1'b0;
            cfg_err_q     <= 1'b0;
            sig_a_q       <= 1'b0;
            sig_b_q       <= 1'b0;
            tick_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_a_q       <= cnt_a_d;
            cnt_b_q       <= cnt_b_d;
            act_period_q  <= act_period_d;
            act_high_q    <= act_high_d;
            act_delay_q   <= act_delay_d;
            act_valid_q   <= act_valid_d;
            pend_period_q <= pend_period_d;
            pend_high_q   <= pend_high_d;
            pend_delay_q  <= pend_delay_d;
            pend_q        <= pend_d;
            cfg_ok_q      <= cfg_ok_d;
            cfg_err_q     <= cfg_err_d;
            sig_a_q       <= sig_a_d;
            sig_b_q       <= sig_b_d;
            tick_q        <= tick_d;
        end
    end

    assign bus.cfg_ok      = cfg_ok_q;
    assign bus.cfg_err     = cfg_err_q;
    assign bus.sig_a       = sig_a_q;
    assign bus.sig_b       = sig_b_q;
    assign bus.period_tick = tick_q;
    assign bus.running     = running;
endmodule

// File: tb/tb_phase_pair_gen.sv
// Directed bench for phase_pair_gen: edge timestamps are captured on the falling clock edge
// and compared against hand-derived cycle numbers relative to the cycle the test began.
module tb_phase_pair_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;
    int   e;

    int   ar[$];
    int   af[$];
    int   br[$];
    int   bf[$];
    int   tk[$];
    logic pa = 1'b0;
    logic pb = 1'b0;

    phase_pair_if #(.CNT_W(32)) bus ();

    phase_pair_gen #(.CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.sig_a && !pa) ar.push_back(cyc);
        if (!bus.sig_a && pa) af.push_back(cyc);
        if (bus.sig_b && !pb) br.push_back(cyc);
        if (!bus.sig_b && pb) bf.push_back(cyc);
        if (bus.period_tick)  tk.push_back(cyc);
        pa <= bus.sig_a;
        pb <= bus.sig_b;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clrq();
        ar.delete(); af.delete(); br.delete(); bf.delete(); tk.delete();
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.enable   = 1'b0;
        bus.cfg_load = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic load(input int p, input int h, input int d);
        bus.cfg_load   = 1'b1;
        bus.cfg_period = p;
        bus.cfg_high   = h;
        bus.cfg_delay  = d;
        step(1);
        bus.cfg_load   = 1'b0;
    endtask

    initial begin
        bus.enable     = 1'b0;
        bus.cfg_load   = 1'b0;
        bus.cfg_period = '0;
        bus.cfg_high   = '0;
        bus.cfg_delay  = '0;

        // Reset state
        do_reset();
        chk("rst_sig_a",   bus.sig_a, 0);
        chk("rst_sig_b",   bus.sig_b, 0);
        chk("rst_running", bus.running, 0);
        chk("rst_cfg_ok",  bus.cfg_ok, 0);
        chk("rst_cfg_err", bus.cfg_err, 0);
        chk("rst_tick",    bus.period_tick, 0);

        // Basic waveform: period 10, high 5, delay 0
        clrq();
        e = cyc;
        bus.enable = 1'b1;
        load(10, 5, 0);
        chk("t1_ok",  bus.cfg_ok, 1);
        chk("t1_err", bus.cfg_err, 0);
        step(40);
        chk("t1_first_rise", ar[0], e + 4);
        chk("t1_period",     ar[1] - ar[0], 10);
        chk("t1_high",       af[0] - ar[0], 5);
        chk("t1_b_rise",     br[0], ar[0]);
        chk("t1_b_fall",     bf[0], af[0]);
        chk("t1_tick0",      tk[0], e + 13);
        chk("t1_tick_per",   tk[1] - tk[0], 10);
        chk("t1_running",    bus.running, 1);

        // Quarter-period lag: period 40, high 20, delay 10
        do_reset();
        clrq();
        e = cyc;
        bus.enable = 1'b1;
        load(40, 20, 10);
        chk("t2_ok", bus.cfg_ok, 1);
        step(100);
        chk("t2_first_rise", ar[0], e + 4);
        chk("t2_lag0",       br[0] - ar[0], 10);
        chk("t2_lag1",       br[1] - ar[1], 10);
        chk("t2_a_high",     af[0] - ar[0], 20);
        chk("t2_b_high",     bf[0] - br[0], 20);
        chk("t2_period",     ar[1] - ar[0], 40);
        chk("t2_phase_deg",  (br[0] - ar[0]) * 360 / 40, 90);

        // Rejected configs leave the running waveform alone
        load(1, 1, 0);
        chk("t3_err_p1",  bus.cfg_err, 1);
        chk("t3_ok_p1",   bus.cfg_ok, 0);
        load(10, 5, 12);
        chk("t3_err_dly", bus.cfg_err, 1);
        chk("t3_ok_dly",  bus.cfg_ok, 0);
        load(10, 0, 0);
        chk("t3_err_h0",  bus.cfg_err, 1);
        chk("t3_ok_h0",   bus.cfg_ok, 0);
        clrq();
        step(100);
        chk("t3_period", ar[1] - ar[0], 40);
        chk("t3_tickper", tk[1] - tk[0], 40);
        chk("t3_lag",    (br[0] - ar[0] + 40) % 40, 10);
        chk("t3_high",   (af[0] - ar[0] + 40) % 40, 20);

        // Mid-run reload: 10/5/0 -> 20/4/5, loaded at cnt_a=3
        do_reset();
        clrq();
        e = cyc;
        bus.enable = 1'b1;
        load(10, 5, 0);
        step(25);
        clrq();
        load(20, 4, 5);
        chk("t4_ok", bus.cfg_ok, 1);
        step(33);
        chk("t4_old_a_fall", af[0], e + 29);
        chk("t4_old_b_fall", bf[0], e + 29);
        chk("t4_apply_tick", tk[0], e + 33);
        chk("t4_new_a_rise", ar[0], e + 34);
        chk("t4_new_a_fall", af[1], e + 38);
        chk("t4_new_b_rise", br[0], e + 39);
        chk("t4_new_b_fall", bf[1], e + 43);
        chk("t4_tick1",      tk[1], e + 53);
        chk("t4_a_rise1",    ar[1], e + 54);

        // Enable drop at cnt_a=3: period completes, then IDLE
        do_reset();
        clrq();
        e = cyc;
        bus.enable = 1'b1;
        load(10, 5, 0);
        step(15);
        bus.enable = 1'b0;
        step(6);
        chk("t5_run_before_wrap", bus.running, 1);
        step(1);
        chk("t5_run_after_wrap",  bus.running, 0);
        chk("t5_sig_a_idle",      bus.sig_a, 0);
        chk("t5_sig_b_idle",      bus.sig_b, 0);
        chk("t5_last_tick",       bus.period_tick, 1);
        clrq();
        step(7);
        chk("t5_no_rise", ar.size(), 0);
        chk("t5_idle",    bus.running, 0);

        // Re-enable, then reset in the middle of the high phase
        bus.enable = 1'b1;
        step(4);
        chk("t5_high_before_rst", bus.sig_a, 1);
        rst = 1'b1;
        step(1);
        chk("t5_rst_sig_a",   bus.sig_a, 0);
        chk("t5_rst_sig_b",   bus.sig_b, 0);
        chk("t5_rst_running", bus.running, 0);
        chk("t5_rst_tick",    bus.period_tick, 0);
        rst = 1'b0;
        clrq();
        step(12);
        chk("t5_no_cfg_idle",  bus.running, 0);
        chk("t5_no_cfg_rises", ar.size(), 0);

        // Load exactly on the wrap cycle: new values apply one period later
        do_reset();
        clrq();
        e = cyc;
        bus.enable = 1'b1;
        load(10, 5, 0);
        step(21);
        clrq();
        load(20, 4, 5);
        chk("t6_ok", bus.cfg_ok, 1);
        step(37);
        chk("t6_tick0",   tk[0], e + 23);
        chk("t6_tick1",   tk[1], e + 33);
        chk("t6_tick2",   tk[2], e + 53);
        chk("t6_a_rise0", ar[0], e + 24);
        chk("t6_a_fall0", af[0], e + 29);
        chk("t6_b_rise0", br[0], e + 24);
        chk("t6_a_rise1", ar[1], e + 34);
        chk("t6_a_fall1", af[1], e + 38);
        chk("t6_b_rise1", br[1], e + 39);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
